// File: rtl/vx_commit_arbiter.sv
// Writeback commit arbiter for one issue slot.
// Collects result beats from NUM_UNITS execution units, grants them
// round-robin, keeps multi-beat results contiguous until eop, and drives
// a registered writeback stream plus a committed-instruction counter.
module vx_commit_arbiter #(
    parameter int NUM_UNITS     = 4,
    parameter int NUM_THREADS   = 4,
    parameter int XLEN          = 32,
    parameter int NW_BITS       = 2,
    parameter int NR_BITS       = 6,
    parameter int UUID_WIDTH    = 44,
    parameter int PERF_CTR_BITS = 44,
    parameter int DATAW         = UUID_WIDTH + NW_BITS + XLEN + NUM_THREADS + NR_BITS
                                  + NUM_THREADS * XLEN + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_UNITS-1:0]          in_valid,
    input  logic [NUM_UNITS*DATAW-1:0]    in_data,
    output logic [NUM_UNITS-1:0]          in_ready,
    output logic                          wb_valid,
    output logic [UUID_WIDTH-1:0]         wb_uuid,
    output logic [NW_BITS-1:0]            wb_wid,
    output logic [XLEN-1:0]               wb_PC,
    output logic [NUM_THREADS-1:0]        wb_tmask,
    output logic [NR_BITS-1:0]            wb_rd,
    output logic [NUM_THREADS*XLEN-1:0]   wb_data,
    output logic                          wb_eop,
    output logic [PERF_CTR_BITS-1:0]      commit_count
);

    localparam int IDX_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int LANES_W  = NUM_THREADS * XLEN;
    localparam int DAT_LSB  = 1;
    localparam int RD_LSB   = DAT_LSB + LANES_W;
    localparam int TM_LSB   = RD_LSB + NR_BITS;
    localparam int PC_LSB   = TM_LSB + NUM_THREADS;
    localparam int WID_LSB  = PC_LSB + XLEN;
    localparam int UUID_LSB = WID_LSB + NW_BITS;

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    lock_state_e            state;
    logic [IDX_W-1:0]       lock_id;
    logic [IDX_W-1:0]       rr_ptr;

    logic [NUM_UNITS-1:0]   grant;
    logic [IDX_W-1:0]       win_id;
    logic [IDX_W-1:0]       scan;
    logic                   found;
    logic [DATAW-1:0]       beat;
    logic                   xfer;

    // Successor of a unit index, wrapping N-1 -> 0 (constant 0 when N=1).
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NUM_UNITS - 1))
            return '0;
        return idx + 1'b1;
    endfunction

    // Grant selection: locked owner only, otherwise first valid unit from rr_ptr.
    always_comb begin
        grant  = '0;
        win_id = '0;
        scan   = rr_ptr;
        found  = 1'b0;
        if (state == ST_LOCKED) begin
            if (in_valid[lock_id]) begin
                grant[lock_id] = 1'b1;
                win_id         = lock_id;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_UNITS; k++) begin
                if (!found && in_valid[scan]) begin
                    found       = 1'b1;
                    grant[scan] = 1'b1;
                    win_id      = scan;
                end
                scan = next_idx(scan);
            end
        end
    end

    // Select the granted unit's beat (grant is one-hot or zero).
    always_comb begin
        beat = '0;
        for (int unsigned k = 0; k < NUM_UNITS; k++) begin
            if (grant[k])
                beat = in_data[k*DATAW +: DATAW];
        end
    end

    assign in_ready = reset ? '0 : grant;
    assign xfer     = |in_ready;

    // Arbitration state, writeback register and commit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_OPEN;
            lock_id      <= '0;
            rr_ptr       <= '0;
            wb_valid     <= 1'b0;
            wb_uuid      <= '0;
            wb_wid       <= '0;
            wb_PC        <= '0;
            wb_tmask     <= '0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_eop       <= 1'b0;
            commit_count <= '0;
        end else begin
            wb_valid <= xfer;
            if (xfer) begin
                wb_uuid  <= beat[UUID_LSB +: UUID_WIDTH];
                wb_wid   <= beat[WID_LSB +: NW_BITS];
                wb_PC    <= beat[PC_LSB +: XLEN];
                wb_tmask <= beat[TM_LSB +: NUM_THREADS];
                wb_rd    <= beat[RD_LSB +: NR_BITS];
                wb_data  <= beat[DAT_LSB +: LANES_W];
                wb_eop   <= beat[0];
                if (beat[0]) begin
                    commit_count <= commit_count + 1'b1;
                    state        <= ST_OPEN;
                    rr_ptr       <= next_idx(win_id);
                end else begin
                    state   <= ST_LOCKED;
                    lock_id <= win_id;
                end
            end
        end
    end

`ifndef SYNTHESIS
    a_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(in_ready));

    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_hold_chk
        a_data_hold: assert property (@(posedge clk) disable iff (reset)
            ($past(in_valid[g] && !in_ready[g]) && in_valid[g])
                |-> $stable(in_data[g*DATAW +: DATAW]));
    end
`endif

endmodule
